// File: rtl/rhs_stim_pkg.sv
// Shared types and constants for the RHS stimulation pulse-train sequencer.
package rhs_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PH_A,
    ST_PH_B,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [1:0] PH_OFF = 2'b00;
  localparam logic [1:0] PH_A   = 2'b01;
  localparam logic [1:0] PH_B   = 2'b10;

  localparam logic [1:0] CFG_CH  = 2'd0;
  localparam logic [1:0] CFG_PW  = 2'd1;
  localparam logic [1:0] CFG_DLY = 2'd2;
  localparam logic [1:0] CFG_CNT = 2'd3;

  localparam int unsigned CFG_POS_LSB = 0;
  localparam int unsigned CFG_NEG_LSB = 5;
  localparam int unsigned CFG_BIP_BIT = 10;
  localparam int unsigned CFG_EN_BIT  = 11;
  localparam int unsigned CFG_INF_BIT = 12;

  function automatic int unsigned slot_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rhs_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV cycles, phase-aligned to the
// cycle in which restart is asserted (that cycle counts as cycle 0).
module rhs_tick_gen #(
  parameter int unsigned TICK_DIV = 2800
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= (TICK_DIV > 1) ? CW'(1) : '0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The stale count is ignored in the restart cycle unless every cycle ticks.
  assign tick = (cnt == CW'(TICK_DIV - 1)) && (!restart || (TICK_DIV == 1));

endmodule

// File: rtl/rhs_stim_sequencer.sv
// Multi-slot stimulation pulse-train sequencer: runs enabled slots in ascending
// order and drives the channel/phase/strobe interface of the SPI command generator.
module rhs_stim_sequencer
  import rhs_stim_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CH_W      = 5,
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned TICK_DIV  = 2800
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cfg_we,
  input  logic [slot_w(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [1:0]                   cfg_field,
  input  logic [31:0]                  cfg_wdata,
  input  logic                         stim_en,
  output logic                         stim_active,
  output logic [1:0]                   stim_phase,
  output logic [CH_W-1:0]              stim_pos_ch,
  output logic [CH_W-1:0]              stim_neg_ch,
  output logic                         stim_bipolar,
  output logic [slot_w(NUM_SLOTS)-1:0] stim_slot,
  output logic                         stim_update,
  output logic                         stim_done
);

  localparam int unsigned SW = slot_w(NUM_SLOTS);

  logic [CH_W-1:0]      pos_r [NUM_SLOTS];
  logic [CH_W-1:0]      neg_r [NUM_SLOTS];
  logic [TIME_W-1:0]    pw_r  [NUM_SLOTS];
  logic [TIME_W-1:0]    dly_r [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] bip_r, en_r, inf_r;

  logic cfg_unused;
  assign cfg_unused = &{1'b0, cfg_wdata};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        pos_r[i] <= '0;
        neg_r[i] <= '0;
        pw_r[i]  <= '0;
        dly_r[i] <= '0;
        cnt_r[i] <= '0;
      end
      bip_r <= '0;
      en_r  <= '0;
      inf_r <= '0;
    end else if (cfg_we && (32'(cfg_slot) < NUM_SLOTS)) begin
      case (cfg_field)
        CFG_CH: begin
          pos_r[cfg_slot] <= cfg_wdata[CFG_POS_LSB +: CH_W];
          neg_r[cfg_slot] <= cfg_wdata[CFG_NEG_LSB +: CH_W];
          bip_r[cfg_slot] <= cfg_wdata[CFG_BIP_BIT];
          en_r[cfg_slot]  <= cfg_wdata[CFG_EN_BIT];
          inf_r[cfg_slot] <= cfg_wdata[CFG_INF_BIT];
        end
        CFG_PW:  pw_r[cfg_slot]  <= cfg_wdata[TIME_W-1:0];
        CFG_DLY: dly_r[cfg_slot] <= cfg_wdata[TIME_W-1:0];
        default: cnt_r[cfg_slot] <= cfg_wdata[CNT_W-1:0];
      endcase
    end
  end

  state_t            state;
  logic              en_q;
  logic              entry;
  logic              tick;
  logic [SW:0]       idx;
  logic [TIME_W-1:0] tcnt;
  logic [CNT_W-1:0]  pcnt;
  logic [TIME_W-1:0] sh_pw, sh_dly;
  logic [CNT_W-1:0]  sh_cnt;
  logic              sh_inf;
  logic              found;
  logic [SW-1:0]     sel;
  logic [TIME_W-1:0] pw_m1, dly_m1;

  rhs_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .aclk    (aclk),
    .aresetn (aresetn),
    .restart (entry),
    .tick    (tick)
  );

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && en_r[i] && (i >= 32'(idx))) begin
        found = 1'b1;
        sel   = SW'(i);
      end
    end
  end

  assign pw_m1  = (sh_pw == '0) ? '0 : sh_pw - 1'b1;
  assign dly_m1 = sh_dly - 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      en_q         <= 1'b0;
      entry        <= 1'b0;
      idx          <= '0;
      tcnt         <= '0;
      pcnt         <= '0;
      sh_pw        <= '0;
      sh_dly       <= '0;
      sh_cnt       <= '0;
      sh_inf       <= 1'b0;
      stim_active  <= 1'b0;
      stim_phase   <= PH_OFF;
      stim_pos_ch  <= '0;
      stim_neg_ch  <= '0;
      stim_bipolar <= 1'b0;
      stim_slot    <= '0;
      stim_update  <= 1'b0;
      stim_done    <= 1'b0;
    end else begin
      en_q        <= stim_en;
      entry       <= 1'b0;
      stim_update <= 1'b0;
      if ((state != ST_IDLE) && !stim_en) begin
        state       <= ST_IDLE;
        entry       <= 1'b1;
        stim_phase  <= PH_OFF;
        stim_update <= (stim_phase != PH_OFF);
        stim_active <= 1'b0;
        stim_done   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (stim_en && !en_q) begin
              state       <= ST_LOAD;
              entry       <= 1'b1;
              idx         <= '0;
              stim_active <= 1'b1;
              stim_done   <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (found) begin
              state        <= ST_PH_A;
              entry        <= 1'b1;
              idx          <= {1'b0, sel};
              tcnt         <= '0;
              pcnt         <= '0;
              sh_pw        <= pw_r[sel];
              sh_dly       <= dly_r[sel];
              sh_cnt       <= cnt_r[sel];
              sh_inf       <= inf_r[sel];
              stim_slot    <= sel;
              stim_pos_ch  <= pos_r[sel];
              stim_neg_ch  <= neg_r[sel];
              stim_bipolar <= bip_r[sel];
              stim_phase   <= PH_A;
              stim_update  <= 1'b1;
            end else begin
              state       <= ST_DONE;
              entry       <= 1'b1;
              stim_phase  <= PH_OFF;
              stim_update <= (stim_phase != PH_OFF);
              stim_active <= 1'b0;
              stim_done   <= 1'b1;
            end
          end
          ST_PH_A: begin
            if (tick) begin
              if (tcnt == pw_m1) begin
                state       <= ST_PH_B;
                entry       <= 1'b1;
                tcnt        <= '0;
                stim_phase  <= PH_B;
                stim_update <= 1'b1;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
          ST_PH_B: begin
            if (tick) begin
              if (tcnt == pw_m1) begin
                tcnt  <= '0;
                entry <= 1'b1;
                // Outputs hold phase B through LOAD; the next entry decides the strobe.
                if ((pcnt == sh_cnt) && !sh_inf) begin
                  state <= ST_LOAD;
                  idx   <= idx + 1'b1;
                end else begin
                  pcnt        <= pcnt + 1'b1;
                  stim_update <= 1'b1;
                  if (sh_dly == '0) begin
                    state      <= ST_PH_A;
                    stim_phase <= PH_A;
                  end else begin
                    state      <= ST_GAP;
                    stim_phase <= PH_OFF;
                  end
                end
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (tick) begin
              if (tcnt == dly_m1) begin
                state       <= ST_PH_A;
                entry       <= 1'b1;
                tcnt        <= '0;
                stim_phase  <= PH_A;
                stim_update <= 1'b1;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// Directed self-checking bench for rhs_stim_sequencer with a 4-cycle tick.
module tb_rhs_stim_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        cfg_we;
  logic [1:0]  cfg_slot;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_wdata;
  logic        stim_en;
  logic        stim_active;
  logic [1:0]  stim_phase;
  logic [4:0]  stim_pos_ch;
  logic [4:0]  stim_neg_ch;
  logic        stim_bipolar;
  logic [1:0]  stim_slot;
  logic        stim_update;
  logic        stim_done;

  int errors = 0;
  int checks = 0;

  rhs_stim_sequencer #(
    .NUM_SLOTS (4),
    .CH_W      (5),
    .TIME_W    (16),
    .CNT_W     (10),
    .TICK_DIV  (4)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_we       (cfg_we),
    .cfg_slot     (cfg_slot),
    .cfg_field    (cfg_field),
    .cfg_wdata    (cfg_wdata),
    .stim_en      (stim_en),
    .stim_active  (stim_active),
    .stim_phase   (stim_phase),
    .stim_pos_ch  (stim_pos_ch),
    .stim_neg_ch  (stim_neg_ch),
    .stim_bipolar (stim_bipolar),
    .stim_slot    (stim_slot),
    .stim_update  (stim_update),
    .stim_done    (stim_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick_clk();
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg_write(input int slot, input int field, input int data);
    cfg_we    = 1'b1;
    cfg_slot  = 2'(slot);
    cfg_field = 2'(field);
    cfg_wdata = 32'(data);
    tick_clk();
    cfg_we    = 1'b0;
  endtask

  // Leaves the bench in the cycle after LOAD (first PH_A cycle, or DONE).
  task automatic start_seq();
    stim_en = 1'b1;
    tick_clk();
    tick_clk();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #3;
    checks++;
    if ({stim_active, stim_phase, stim_pos_ch, stim_neg_ch, stim_bipolar, stim_slot,
         stim_update, stim_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: act=%b ph=%b pos=%0d neg=%0d bip=%b slot=%0d upd=%b done=%b, required all 0",
               stim_active, stim_phase, stim_pos_ch, stim_neg_ch, stim_bipolar, stim_slot,
               stim_update, stim_done);
    end
    tick_clk();
    aresetn = 1'b1;
    tick_clk();
  endtask

  task automatic test_single_slot();
    int ph [5] = '{1, 2, 0, 1, 2};
    int ln [5] = '{4, 4, 64, 4, 5};
    int ups = 0;
    cfg_write(0, 0, 17 | (18 << 5) | (1 << 11));
    cfg_write(0, 1, 1);
    cfg_write(0, 2, 16);
    cfg_write(0, 3, 1);
    start_seq();
    checks++;
    if (stim_pos_ch !== 5'd17 || stim_neg_ch !== 5'd18 || stim_bipolar !== 1'b0 ||
        stim_active !== 1'b1) begin
      errors++;
      $display("FAIL t1_channels: pos=%0d neg=%0d bip=%b act=%b, required 17 18 0 1",
               stim_pos_ch, stim_neg_ch, stim_bipolar, stim_active);
    end
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < ln[s]; c++) begin
        checks++;
        if (stim_phase !== 2'(ph[s]) || stim_update !== (c == 0)) begin
          errors++;
          $display("FAIL t1_seq seg%0d cyc%0d: phase=%b upd=%b, required %0d %0d",
                   s, c, stim_phase, stim_update, ph[s], (c == 0));
        end
        if (stim_update === 1'b1) ups++;
        tick_clk();
      end
    end
    checks++;
    if (stim_phase !== 2'b00 || stim_update !== 1'b1 || stim_done !== 1'b1 ||
        stim_active !== 1'b0) begin
      errors++;
      $display("FAIL t1_done_entry: phase=%b upd=%b done=%b act=%b, required 00 1 1 0",
               stim_phase, stim_update, stim_done, stim_active);
    end
    checks++;
    if (ups !== 5) begin
      errors++;
      $display("FAIL t1_update_count: got %0d, required 5", ups);
    end
    tick_clk();
    checks++;
    if (stim_update !== 1'b0 || stim_done !== 1'b1) begin
      errors++;
      $display("FAIL t1_done_hold: upd=%b done=%b, required 0 1", stim_update, stim_done);
    end
    stim_en = 1'b0;
    tick_clk();
    checks++;
    if (stim_done !== 1'b0 || stim_active !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle: done=%b act=%b, required 0 0", stim_done, stim_active);
    end
  endtask

  task automatic test_multi_slot();
    int sl [7] = '{0, 0, 0, 0, 0, 2, 2};
    int ph [7] = '{1, 2, 0, 1, 2, 1, 2};
    int ln [7] = '{4, 4, 64, 4, 5, 8, 9};
    int ep, en, eb;
    cfg_write(2, 0, 3 | (4 << 5) | (1 << 10) | (1 << 11));
    cfg_write(2, 1, 2);
    cfg_write(2, 2, 0);
    cfg_write(2, 3, 0);
    start_seq();
    for (int s = 0; s < 7; s++) begin
      ep = (sl[s] == 0) ? 17 : 3;
      en = (sl[s] == 0) ? 18 : 4;
      eb = (sl[s] == 0) ? 0 : 1;
      for (int c = 0; c < ln[s]; c++) begin
        checks++;
        if (stim_phase !== 2'(ph[s]) || stim_update !== (c == 0) ||
            stim_slot !== 2'(sl[s]) || stim_bipolar !== 1'(eb) ||
            stim_pos_ch !== 5'(ep) || stim_neg_ch !== 5'(en)) begin
          errors++;
          $display("FAIL t2_seq seg%0d cyc%0d: ph=%b upd=%b slot=%0d bip=%b pos=%0d neg=%0d, required %0d %0d %0d %0d %0d %0d",
                   s, c, stim_phase, stim_update, stim_slot, stim_bipolar, stim_pos_ch,
                   stim_neg_ch, ph[s], (c == 0), sl[s], eb, ep, en);
        end
        tick_clk();
      end
    end
    checks++;
    if (stim_phase !== 2'b00 || stim_update !== 1'b1 || stim_done !== 1'b1) begin
      errors++;
      $display("FAIL t2_done: phase=%b upd=%b done=%b, required 00 1 1",
               stim_phase, stim_update, stim_done);
    end
    stim_en = 1'b0;
    tick_clk();
  endtask

  task automatic test_abort();
    cfg_write(2, 0, 0);
    cfg_write(0, 0, 17 | (18 << 5) | (1 << 11) | (1 << 12));
    cfg_write(0, 1, 1);
    cfg_write(0, 2, 2);
    start_seq();
    // second PH_B begins 4+4+8+4 = 20 cycles after the first PH_A cycle
    for (int i = 0; i < 22; i++) tick_clk();
    checks++;
    if (stim_phase !== 2'b10 || stim_update !== 1'b0) begin
      errors++;
      $display("FAIL t3_pre_abort: phase=%b upd=%b, required 10 0", stim_phase, stim_update);
    end
    stim_en = 1'b0;
    tick_clk();
    checks++;
    if (stim_phase !== 2'b00 || stim_update !== 1'b1 || stim_done !== 1'b0 ||
        stim_active !== 1'b0) begin
      errors++;
      $display("FAIL t3_abort: phase=%b upd=%b done=%b act=%b, required 00 1 0 0",
               stim_phase, stim_update, stim_done, stim_active);
    end
    tick_clk();
    checks++;
    if (stim_update !== 1'b0 || stim_active !== 1'b0) begin
      errors++;
      $display("FAIL t3_idle: upd=%b act=%b, required 0 0", stim_update, stim_active);
    end
  endtask

  task automatic test_async_reset();
    start_seq();
    tick_clk();
    #2;
    aresetn = 1'b0;
    stim_en = 1'b0;
    #1;
    checks++;
    if ({stim_active, stim_phase, stim_pos_ch, stim_neg_ch, stim_bipolar, stim_slot,
         stim_update, stim_done} !== '0) begin
      errors++;
      $display("FAIL t4_async_clear: act=%b ph=%b pos=%0d neg=%0d upd=%b done=%b, required all 0",
               stim_active, stim_phase, stim_pos_ch, stim_neg_ch, stim_update, stim_done);
    end
    tick_clk();
    aresetn = 1'b1;
    tick_clk();
    stim_en = 1'b1;
    tick_clk();
    checks++;
    if (stim_update !== 1'b0 || stim_active !== 1'b1) begin
      errors++;
      $display("FAIL t4_load: upd=%b act=%b, required 0 1", stim_update, stim_active);
    end
    tick_clk();
    checks++;
    if (stim_done !== 1'b1 || stim_update !== 1'b0 || stim_active !== 1'b0 ||
        stim_phase !== 2'b00) begin
      errors++;
      $display("FAIL t4_empty_done: done=%b upd=%b act=%b ph=%b, required 1 0 0 00",
               stim_done, stim_update, stim_active, stim_phase);
    end
    stim_en = 1'b0;
    tick_clk();
  endtask

  task automatic test_shadow_rewrite();
    int ph [4] = '{1, 2, 1, 2};
    int ln [4] = '{4, 4, 4, 5};
    int k = 0;
    cfg_write(0, 0, 17 | (18 << 5) | (1 << 11));
    cfg_write(0, 1, 1);
    cfg_write(0, 2, 0);
    cfg_write(0, 3, 1);
    start_seq();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < ln[s]; c++) begin
        if (k == 1) begin
          cfg_we    = 1'b1;
          cfg_slot  = 2'd0;
          cfg_field = 2'd1;
          cfg_wdata = 32'd3;
        end
        if (k == 2) cfg_we = 1'b0;
        checks++;
        if (stim_phase !== 2'(ph[s]) || stim_update !== (c == 0)) begin
          errors++;
          $display("FAIL t5_old_pw seg%0d cyc%0d: phase=%b upd=%b, required %0d %0d",
                   s, c, stim_phase, stim_update, ph[s], (c == 0));
        end
        tick_clk();
        k++;
      end
    end
    checks++;
    if (stim_done !== 1'b1 || stim_phase !== 2'b00) begin
      errors++;
      $display("FAIL t5_done: done=%b phase=%b, required 1 00", stim_done, stim_phase);
    end
    stim_en = 1'b0;
    tick_clk();
    start_seq();
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (stim_phase !== 2'b01) begin
        errors++;
        $display("FAIL t5_new_pw_a cyc%0d: phase=%b, required 01", c, stim_phase);
      end
      tick_clk();
    end
    checks++;
    if (stim_phase !== 2'b10 || stim_update !== 1'b1) begin
      errors++;
      $display("FAIL t5_new_pw_b: phase=%b upd=%b, required 10 1", stim_phase, stim_update);
    end
    stim_en = 1'b0;
    tick_clk();
  endtask

  task automatic test_retrigger();
    int bad = 0;
    cfg_write(0, 1, 1);
    start_seq();
    for (int i = 0; i < 17; i++) tick_clk();
    checks++;
    if (stim_done !== 1'b1 || stim_update !== 1'b1) begin
      errors++;
      $display("FAIL t6_done: done=%b upd=%b, required 1 1", stim_done, stim_update);
    end
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      if (stim_done !== 1'b1 || stim_active !== 1'b0 || stim_update !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL t6_hold_high: %0d cycles left DONE, required 0", bad);
    end
    stim_en = 1'b0;
    tick_clk();
    checks++;
    if (stim_done !== 1'b0) begin
      errors++;
      $display("FAIL t6_clear: done=%b, required 0", stim_done);
    end
    stim_en = 1'b1;
    tick_clk();
    checks++;
    if (stim_active !== 1'b1 || stim_done !== 1'b0) begin
      errors++;
      $display("FAIL t6_restart: act=%b done=%b, required 1 0", stim_active, stim_done);
    end
    tick_clk();
    checks++;
    if (stim_phase !== 2'b01 || stim_update !== 1'b1) begin
      errors++;
      $display("FAIL t6_restart_pha: phase=%b upd=%b, required 01 1", stim_phase, stim_update);
    end
    stim_en = 1'b0;
    tick_clk();
  endtask

  initial begin
    cfg_we    = 1'b0;
    cfg_slot  = '0;
    cfg_field = '0;
    cfg_wdata = '0;
    stim_en   = 1'b0;
    aresetn   = 1'b0;
    test_reset();
    test_single_slot();
    test_multi_slot();
    test_abort();
    test_async_reset();
    test_shadow_rewrite();
    test_retrigger();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
